// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: run control, instruction-memory port, redirect and decoder-side handshake.
// The fetch unit takes the master modport; memory/decoder models take slave.
interface instruction_fetch_if #(
  parameter int ADDR_W = 16
);
  logic              en;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        occupancy;

  modport master (
    input  en, imem_ack, imem_rdata, redirect, redirect_pc, instr_ready,
    output imem_req, imem_addr, instruction, instr_pc, instr_valid, occupancy
  );

  modport slave (
    output en, imem_ack, imem_rdata, redirect, redirect_pc, instr_ready,
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid, occupancy
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC register, held-until-ack memory request and a 2-entry
// {pc, instruction} buffer feeding the decoder; redirect flushes and restarts.
module instruction_fetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  logic [ADDR_W-1:0] pc;
  logic              pend;
  logic [1:0]        occ;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [ADDR_W-1:0] fifo_pc   [2];
  logic [31:0]       fifo_data [2];
  logic              req;
  logic              valid;
  logic              push;
  logic              pop;

  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] p);
    return p + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // rst gating keeps the combinational outputs quiet while reset is held
  assign req   = !rst && !bus.redirect && (occ != 2'd2) && (bus.en || pend);
  assign valid = !rst && !bus.redirect && (occ != 2'd0);
  assign push  = req && bus.imem_ack;
  assign pop   = valid && bus.instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      pend   <= 1'b0;
      occ    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (bus.redirect) begin
      pc     <= bus.redirect_pc;
      pend   <= 1'b0;
      occ    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      // an unacked request stays armed even if en drops
      pend <= req && !bus.imem_ack;
      if (push) begin
        pc     <= pc_next(pc);
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer payload carries no reset; it is only observed when occupancy is nonzero
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pc;
      fifo_data[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid;
  assign bus.occupancy   = occ;
  assign bus.instruction = (occ != 2'd0) ? fifo_data[rd_ptr] : 32'd0;
  assign bus.instr_pc    = (occ != 2'd0) ? fifo_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, backpressure, stall stability,
// redirect flush, PC wrap and asynchronous reset with a full buffer.
module tb_instruction_fetch;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instruction_fetch_if #(.ADDR_W(16)) bus ();

  instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory returns a word tagged with its own address
  always_comb bus.imem_rdata = 32'h1000_0000 + {16'h0000, bus.imem_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.imem_ack = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.instr_ready = 1'b0;
    #2;
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_occ", {30'd0, bus.occupancy}, 32'd0);
    check("rst_instr", bus.instruction, 32'd0);
    check("rst_ipc", {16'd0, bus.instr_pc}, 32'd0);
    check("rst_addr", {16'd0, bus.imem_addr}, 32'd0);

    // streaming
    cyc();
    rst = 1'b0;
    bus.imem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    check("st_first_req", {31'd0, bus.imem_req}, 32'd1);
    check("st_first_addr", {16'd0, bus.imem_addr}, 32'd0);
    check("st_first_valid", {31'd0, bus.instr_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      check("st_ipc", {16'd0, bus.instr_pc}, i);
      check("st_instr", bus.instruction, 32'h1000_0000 + i);
      check("st_occ", {30'd0, bus.occupancy}, 32'd1);
      check("st_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("st_addr", {16'd0, bus.imem_addr}, i + 1);
    end

    // backpressure
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.instr_ready = 1'b0;
    #1;
    check("bp_c0_addr", {16'd0, bus.imem_addr}, 32'd0);
    check("bp_c0_occ", {30'd0, bus.occupancy}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      cyc();
      #1;
    end
    check("bp_full_occ", {30'd0, bus.occupancy}, 32'd2);
    check("bp_full_req", {31'd0, bus.imem_req}, 32'd0);
    check("bp_full_addr", {16'd0, bus.imem_addr}, 32'd2);
    check("bp_full_ipc", {16'd0, bus.instr_pc}, 32'd0);
    cyc();
    bus.instr_ready = 1'b1;
    #1;
    check("bp_pop0_ipc", {16'd0, bus.instr_pc}, 32'd0);
    check("bp_pop0_req", {31'd0, bus.imem_req}, 32'd0);
    cyc();
    #1;
    check("bp_pop1_ipc", {16'd0, bus.instr_pc}, 32'd1);
    check("bp_pop1_occ", {30'd0, bus.occupancy}, 32'd1);
    check("bp_resume_req", {31'd0, bus.imem_req}, 32'd1);
    check("bp_resume_addr", {16'd0, bus.imem_addr}, 32'd2);
    cyc();
    #1;
    check("bp_pc2_ipc", {16'd0, bus.instr_pc}, 32'd2);
    check("bp_pc2_instr", bus.instruction, 32'h1000_0002);

    // stall: ack low four cycles, en dropped in the second
    cyc();
    bus.imem_ack = 1'b0;
    #1;
    check("sl_c1_ipc", {16'd0, bus.instr_pc}, 32'd3);
    check("sl_c1_req", {31'd0, bus.imem_req}, 32'd1);
    check("sl_c1_addr", {16'd0, bus.imem_addr}, 32'd4);
    cyc();
    bus.en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("sl_req", {31'd0, bus.imem_req}, 32'd1);
      check("sl_addr", {16'd0, bus.imem_addr}, 32'd4);
      cyc();
      #1;
    end
    bus.imem_ack = 1'b1;
    #1;
    check("sl_ack_req", {31'd0, bus.imem_req}, 32'd1);
    check("sl_ack_addr", {16'd0, bus.imem_addr}, 32'd4);
    cyc();
    #1;
    check("sl_post_req", {31'd0, bus.imem_req}, 32'd0);
    check("sl_post_ipc", {16'd0, bus.instr_pc}, 32'd4);
    check("sl_post_instr", bus.instruction, 32'h1000_0004);
    cyc();
    #1;
    check("sl_empty_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("sl_empty_req", {31'd0, bus.imem_req}, 32'd0);

    // redirect with a full buffer and ack high
    cyc();
    bus.en = 1'b1;
    bus.instr_ready = 1'b0;
    #1;
    cyc();
    #1;
    cyc();
    #1;
    check("rd_full_occ", {30'd0, bus.occupancy}, 32'd2);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0040;
    #1;
    check("rd_now_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rd_now_req", {31'd0, bus.imem_req}, 32'd0);
    cyc();
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    check("rd_next_occ", {30'd0, bus.occupancy}, 32'd0);
    check("rd_next_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rd_next_req", {31'd0, bus.imem_req}, 32'd1);
    check("rd_next_addr", {16'd0, bus.imem_addr}, 32'h0040);
    cyc();
    #1;
    check("rd_head_ipc", {16'd0, bus.instr_pc}, 32'h0040);
    check("rd_head_instr", bus.instruction, 32'h1000_0040);
    check("rd_head_occ", {30'd0, bus.occupancy}, 32'd1);

    // wrap
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'hFFFF;
    #1;
    cyc();
    bus.redirect = 1'b0;
    #1;
    check("wr_addr_ffff", {16'd0, bus.imem_addr}, 32'h0000_FFFF);
    cyc();
    #1;
    check("wr_ipc_ffff", {16'd0, bus.instr_pc}, 32'h0000_FFFF);
    check("wr_instr_ffff", bus.instruction, 32'h1000_FFFF);
    check("wr_addr_0", {16'd0, bus.imem_addr}, 32'd0);
    cyc();
    #1;
    check("wr_ipc_0", {16'd0, bus.instr_pc}, 32'd0);
    check("wr_instr_0", bus.instruction, 32'h1000_0000);

    // asynchronous reset while full
    cyc();
    bus.instr_ready = 1'b0;
    #1;
    cyc();
    #1;
    check("ar_full_occ", {30'd0, bus.occupancy}, 32'd2);
    #1;
    rst = 1'b1;
    #1;
    check("ar_occ", {30'd0, bus.occupancy}, 32'd0);
    check("ar_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("ar_req", {31'd0, bus.imem_req}, 32'd0);
    check("ar_instr", bus.instruction, 32'd0);
    check("ar_ipc", {16'd0, bus.instr_pc}, 32'd0);
    rst = 1'b0;
    #1;
    check("ar_rel_req", {31'd0, bus.imem_req}, 32'd1);
    check("ar_rel_addr", {16'd0, bus.imem_addr}, 32'd0);
    cyc();
    #1;
    check("ar_first_ipc", {16'd0, bus.instr_pc}, 32'd0);
    check("ar_first_occ", {30'd0, bus.occupancy}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
